can_rx_fifo: RTL

//  Downstream consumer of can_rx. Captures each received 79-bit frame on i_Rx_DV,

---
 rtl/can_rx_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/can_rx_fifo.sv
// can_rx_fifo
//   Receive-side buffer behind can_rx. Each frame presented on i_Rx_DV is
//   checked for standard-format framing (start bit, IDE and r0 all zero). It can
//   then be screened by an optional 11-bit acceptance filter. Frames that pass
//   are stored as {ID, data} in a show-ahead FIFO. Overruns and malformed frames
//   are counted so that lost traffic is never silent.
//
//   Optional feature macro: CAN_RX_ACCEPT_FILTER_EN
//     defined   : pass = ((ID ^ i_Filt_Id) & i_Filt_Mask) == 0
//     undefined : every well-formed frame passes; filter ports are ignored
//
// Parameters
//   DEPTH   FIFO entries (power of 2, >= 2)
//   ADDR_W  log2(DEPTH)
//
// Ports
//   i_Clock      rising-edge clock
//   i_Rst_n      synchronous reset, active low
//   i_Rx_DV      one-cycle strobe: i_Rx_Frame valid
//   i_Rx_Frame   [0]=start [11:1]=ID [12]=RTR [13]=IDE [14]=r0 [78:15]=data
//   i_Filt_Id    acceptance ID (filter build only)
//   i_Filt_Mask  acceptance mask, 1 = compare (filter build only)
//   i_Rd_En      pop head entry
//   i_Ovr_Clr    clear o_Overrun and o_Drop_Cnt
//   o_Rd_Valid   head entry valid
//   o_Rd_Id      head entry ID (0 while empty)
//   o_Rd_Data    head entry data (0 while empty)
//   o_Count      occupied entries 0..DEPTH
//   o_Empty      o_Count == 0
//   o_Full       o_Count == DEPTH
//   o_Overrun    sticky: accepted frame dropped because FIFO was full
//   o_Drop_Cnt   saturating count of dropped and malformed frames
module can_rx_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [78:0]       i_Rx_Frame,
  input  logic [10:0]       i_Filt_Id,
  input  logic [10:0]       i_Filt_Mask,
  input  logic              i_Rd_En,
  input  logic              i_Ovr_Clr,
  output logic              o_Rd_Valid,
  output logic [10:0]       o_Rd_Id,
  output logic [63:0]       o_Rd_Data,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Empty,
  output logic              o_Full,
  output logic              o_Overrun,
  output logic [7:0]        o_Drop_Cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Frame fields
  logic        frame_start;
  logic [10:0] frame_id;
  logic        frame_ide;
  logic        frame_r0;
  logic [63:0] frame_data;

  assign frame_start = i_Rx_Frame[0];
  assign frame_id    = i_Rx_Frame[11:1];
  assign frame_ide   = i_Rx_Frame[13];
  assign frame_r0    = i_Rx_Frame[14];
  assign frame_data  = i_Rx_Frame[78:15];

  // RTR is deliberately not stored; filter ports are idle in the default build.
  logic filt_pass;
  logic unused_bits;

`ifdef CAN_RX_ACCEPT_FILTER_EN
  assign filt_pass   = ((frame_id ^ i_Filt_Id) & i_Filt_Mask) == '0;
  assign unused_bits = i_Rx_Frame[12];
`else
  assign filt_pass   = 1'b1;
  assign unused_bits = ^{i_Rx_Frame[12], i_Filt_Id, i_Filt_Mask};
`endif

  // Storage and state
  logic [74:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic [7:0]        drop_cnt;

  // Control decode
  logic well_formed;
  logic accept;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic ovr_drop;
  logic bad_drop;
  logic drop_evt;

  always_comb begin
    empty       = (count == '0);
    full        = (count == FULL_CNT);
    well_formed = !frame_start && !frame_ide && !frame_r0;
    accept      = well_formed && filt_pass;
    pop         = i_Rd_En && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push        = i_Rx_DV && accept && (!full || pop);
    ovr_drop    = i_Rx_DV && accept && full && !pop;
    bad_drop    = i_Rx_DV && !well_formed;
    drop_evt    = ovr_drop || bad_drop;
  end

  // Entry RAM: no reset, pointers alone define what is valid.
  always_ff @(posedge i_Clock) begin
    if (i_Rst_n && push) begin
      mem[wr_ptr] <= {frame_id, frame_data};
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Clear and a new drop in the same cycle: the drop is recorded on top of the clear.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (i_Ovr_Clr) begin
      overrun  <= ovr_drop;
      drop_cnt <= drop_evt ? 8'd1 : 8'd0;
    end else begin
      if (ovr_drop) begin
        overrun <= 1'b1;
      end
      if (drop_evt && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Show-ahead read port; forced to zero while empty so reset and stale RAM never leak.
  logic [74:0] head;

  always_comb begin
    head = mem[rd_ptr];
    if (empty) begin
      head = '0;
    end
  end

  assign o_Rd_Valid = !empty;
  assign o_Rd_Id    = head[74:64];
  assign o_Rd_Data  = head[63:0];
  assign o_Count    = count;
  assign o_Empty    = empty;
  assign o_Full     = full;
  assign o_Overrun  = overrun;
  assign o_Drop_Cnt = drop_cnt;

endmodule
